// File: rtl/mult_unit_if.sv
// rtl/mult_unit_if.sv - operand/result bundle for the iterative multiplier
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - shift-and-add MULT/MULTU unit producing HI/LO over WIDTH cycles
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mult_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic             accept;
  logic             last_iter;

  // Multiplicand is kept pre-extended and shifted left once per iteration,
  // so the add always uses it at the weight of the current multiplier bit.
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    product;

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // MULT works on magnitudes; the most negative value maps onto itself,
  // which is also its correct unsigned magnitude.
  assign a_mag = (bus.signed_op && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
  assign b_mag = (bus.signed_op && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

  // The final iteration's sum is used directly so the result lands on the
  // RUN->DONE edge without an extra cycle.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product = neg_q ? (~acc_sum + PW'(1)) : acc_sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and operand-accept decode; start is ignored while running
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latch, per-cycle shift-and-add, and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (accept) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_mag};
      mplier_q <= b_mag;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end else if (state_q == S_RUN) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last_iter) begin
        {hi_q, lo_q} <= product;
      end
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
